// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regwb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              we;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_commit_t;

    function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
        return r == REG_ZERO;
    endfunction

endpackage

// File: rtl/regwb_fifo.sv
// Long-latency result queue with per-entry kill flags, kill-by-register and
// two register-match queries used for decode stall checks.
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [REG_W-1:0]  push_reg,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [REG_W-1:0]  kill_reg,
    input  logic [REG_W-1:0]  q1_reg,
    input  logic [REG_W-1:0]  q2_reg,
    output logic              q1_hit,
    output logic              q2_hit,
    output logic [REG_W-1:0]  head_reg,
    output logic [DATA_W-1:0] head_data,
    output logic              head_live,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    logic [REG_W-1:0]  reg_q  [DEPTH];
    logic [REG_W-1:0]  reg_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic              vld_q  [DEPTH];
    logic              vld_d  [DEPTH];
    logic              kill_q [DEPTH];
    logic              kill_d [DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       count_q, count_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            reg_d[i]  = reg_q[i];
            data_d[i] = data_q[i];
            vld_d[i]  = vld_q[i];
            kill_d[i] = kill_q[i];
            if (kill_en && vld_q[i] && (reg_q[i] == kill_reg)) begin
                kill_d[i] = 1'b1;
            end
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
        end
        // An entry pushed alongside an ALU write to the same register is older than it.
        if (push) begin
            reg_d[wr_ptr_q]  = push_reg;
            data_d[wr_ptr_q] = push_data;
            vld_d[wr_ptr_q]  = 1'b1;
            kill_d[wr_ptr_q] = is_zero_reg(push_reg) || (kill_en && (push_reg == kill_reg));
        end
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]  <= 1'b0;
                kill_q[i] <= 1'b0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]  <= vld_d[i];
                kill_q[i] <= kill_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            reg_q[i]  <= reg_d[i];
            data_q[i] <= data_d[i];
        end
    end

    always_comb begin
        q1_hit = 1'b0;
        q2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !kill_q[i] && (reg_q[i] == q1_reg)) q1_hit = 1'b1;
            if (vld_q[i] && !kill_q[i] && (reg_q[i] == q2_reg)) q2_hit = 1'b1;
        end
    end

    assign head_reg  = reg_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign head_live = !empty && vld_q[rd_ptr_q] && !kill_q[rd_ptr_q];

endmodule

// File: rtl/regwb.sv
// Writeback arbiter: ALU results take the register-file port first, queued
// long-latency results fill idle slots, and a starving head eventually stalls the ALU.
module regwb
    import regwb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_reg,
    input  logic [31:0] ld_data,
    input  logic [4:0]  read1,
    input  logic [4:0]  read2,
    output logic        pend1,
    output logic        pend2,
    output logic        regwrite,
    output logic [4:0]  wrreg,
    output logic [31:0] wrdata
);

    localparam int AGE_W = $clog2(STARVE_MAX + 1);

    logic              stall;
    logic              alu_write;
    logic              push;
    logic              pop;
    logic              q1_hit, q2_hit;
    logic [REG_W-1:0]  head_reg;
    logic [DATA_W-1:0] head_data;
    logic              head_live;
    logic              fifo_empty, fifo_full;
    logic [AGE_W-1:0]  age_q, age_d;
    wb_commit_t        commit_q, commit_d;

    regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_reg  (ld_reg),
        .push_data (ld_data),
        .pop       (pop),
        .kill_en   (alu_write),
        .kill_reg  (alu_reg),
        .q1_reg    (read1),
        .q2_reg    (read2),
        .q1_hit    (q1_hit),
        .q2_hit    (q2_hit),
        .head_reg  (head_reg),
        .head_data (head_data),
        .head_live (head_live),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        stall     = (age_q == AGE_W'(STARVE_MAX)) && head_live;
        alu_ready = !reset && !stall;
        ld_ready  = !reset && !fifo_full;
        alu_write = alu_valid && alu_ready && !is_zero_reg(alu_reg);
        push      = ld_valid && ld_ready;
        pop       = !reset && !alu_write && !fifo_empty;

        // Killed heads still consume the pop slot but leave the write port idle.
        commit_d    = commit_q;
        commit_d.we = 1'b0;
        if (alu_write) begin
            commit_d = '{we: 1'b1, rd: alu_reg, data: alu_data};
        end else if (pop && head_live) begin
            commit_d = '{we: 1'b1, rd: head_reg, data: head_data};
        end

        age_d = age_q;
        if (pop) begin
            age_d = '0;
        end else if (head_live && alu_write && (age_q != AGE_W'(STARVE_MAX))) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_q <= '0;
            age_q    <= '0;
        end else begin
            commit_q <= commit_d;
            age_q    <= age_d;
        end
    end

    assign pend1    = !reset && !is_zero_reg(read1) && q1_hit;
    assign pend2    = !reset && !is_zero_reg(read2) && q2_hit;
    assign regwrite = commit_q.we;
    assign wrreg    = commit_q.rd;
    assign wrdata   = commit_q.data;

endmodule
